// File: rtl/md5_search_pkg.sv
// rtl/md5_search_pkg.sv - shared types and constants for the MD5 search controller
package md5_search_pkg;

    // One-hot controller states
    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_WARM  = 6'b000010,
        ST_RUN   = 6'b000100,
        ST_DRAIN = 6'b001000,
        ST_FOUND = 6'b010000,
        ST_DONE  = 6'b100000
    } state_e;

    // Bit positions inside the status vector {paused, running, warming, found, done}
    localparam int STAT_PAUSED  = 4;
    localparam int STAT_RUNNING = 3;
    localparam int STAT_WARMING = 2;
    localparam int STAT_FOUND   = 1;
    localparam int STAT_DONE    = 0;

    // Base status pattern per state; enable- and hit-dependent bits are patched in later
    localparam logic [4:0] STAT_V_IDLE  = 5'b10000;
    localparam logic [4:0] STAT_V_WARM  = 5'b01100;
    localparam logic [4:0] STAT_V_RUN   = 5'b01000;
    localparam logic [4:0] STAT_V_FOUND = 5'b00010;
    localparam logic [4:0] STAT_V_DONE  = 5'b00001;

    // Lane index width; never below one bit so the lane field is always present
    function automatic int lane_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/md5_search_ctrl_if.sv
// rtl/md5_search_ctrl_if.sv - controller to hash-pipeline lane bundle
interface md5_search_ctrl_if #(
    parameter int NUM_LANES = 8,
    parameter int CW        = 29
);
    logic [CW-1:0]        base_out;
    logic                 pipe_en;
    logic [NUM_LANES-1:0] lane_found;

    modport master (
        output base_out,
        output pipe_en,
        input  lane_found
    );

    modport slave (
        input  base_out,
        input  pipe_en,
        output lane_found
    );
endinterface

// File: rtl/md5_hit_encoder.sv
// rtl/md5_hit_encoder.sv - reduces per-lane match flags to any / lowest index / multi
module md5_hit_encoder #(
    parameter int NUM_LANES = 8,
    parameter int LANE_BITS = 3
) (
    input  logic [NUM_LANES-1:0] lane_found,
    output logic                 hit_any,
    output logic [LANE_BITS-1:0] hit_idx,
    output logic                 hit_multi
);

    assign hit_any   = |lane_found;
    // Clearing the lowest set bit leaves something only when two or more bits were set
    assign hit_multi = |(lane_found & (lane_found - NUM_LANES'(1)));

    // Scan downwards so the lowest set lane is the one left standing
    always_comb begin
        hit_idx = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (lane_found[i]) begin
                hit_idx = LANE_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/md5_search_ctrl.sv
// rtl/md5_search_ctrl.sv - base-count issue, warm-up, drain and hit capture for the MD5 search
module md5_search_ctrl
    import md5_search_pkg::*;
#(
    parameter int  NUM_LANES    = 8,
    parameter int  CW           = 29,
    parameter int  PIPE_LATENCY = 64,
    localparam int LANE_BITS    = lane_bits(NUM_LANES)
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    found_ack,
    md5_search_ctrl_if.master       lanes,
    output logic                    status_paused,
    output logic                    status_running,
    output logic                    status_warming,
    output logic                    status_found,
    output logic                    status_done,
    output logic [CW+LANE_BITS-1:0] match_value,
    output logic [7:0]              hit_count,
    output logic                    multi_hit
);

    localparam int             CNT_W    = $clog2(PIPE_LATENCY + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PIPE_LATENCY - 1);
    localparam logic [CW-1:0]  LAT_CW   = CW'(PIPE_LATENCY);
    localparam logic [CW-1:0]  BASE_MAX = '1;

    state_e                  state_q, state_d;
    state_e                  ret_q, ret_d;
    logic [CW-1:0]           base_q, base_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CW+LANE_BITS-1:0] match_value_q, match_value_d;
    logic [7:0]              hit_count_q, hit_count_d;
    logic                    multi_hit_q, multi_hit_d;

    logic                    pipe_en;
    logic [4:0]              status;
    logic                    capture;
    logic                    hit_any;
    logic                    hit_multi;
    logic [LANE_BITS-1:0]    hit_idx;

    md5_hit_encoder #(
        .NUM_LANES (NUM_LANES),
        .LANE_BITS (LANE_BITS)
    ) u_hit_encoder (
        .lane_found (lanes.lane_found),
        .hit_any    (hit_any),
        .hit_idx    (hit_idx),
        .hit_multi  (hit_multi)
    );

    // State and datapath registers; reset wipes every captured result
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ret_q         <= ST_RUN;
            base_q        <= '0;
            cnt_q         <= '0;
            match_value_q <= '0;
            hit_count_q   <= '0;
            multi_hit_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ret_q         <= ret_d;
            base_q        <= base_d;
            cnt_q         <= cnt_d;
            match_value_q <= match_value_d;
            hit_count_q   <= hit_count_d;
            multi_hit_q   <= multi_hit_d;
        end
    end

    // Next state: fill/drain counting, last-issue detection and where to go after a hit
    always_comb begin
        state_d       = state_q;
        ret_d         = ret_q;
        base_d        = base_q;
        cnt_d         = cnt_q;
        match_value_d = match_value_q;
        hit_count_d   = hit_count_q;
        multi_hit_d   = multi_hit_q;
        capture       = 1'b0;

        if (pipe_en) begin
            base_d = base_q + CW'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_WARM;
                    cnt_d   = '0;
                end
            end
            ST_WARM: begin
                if (pipe_en) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (pipe_en) begin
                    if (hit_any) begin
                        // A hit on the last issue still owes a full drain after the ack
                        state_d = ST_FOUND;
                        capture = 1'b1;
                        ret_d   = (base_q == BASE_MAX) ? ST_DRAIN : ST_RUN;
                        if (base_q == BASE_MAX) begin
                            cnt_d = '0;
                        end
                    end else if (base_q == BASE_MAX) begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (pipe_en) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (hit_any) begin
                        state_d = ST_FOUND;
                        capture = 1'b1;
                        ret_d   = (cnt_q == LAST_CNT) ? ST_DONE : ST_DRAIN;
                    end else if (cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FOUND: begin
                if (found_ack) begin
                    state_d = ret_q;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The sampled result belongs to the candidate issued PIPE_LATENCY advances ago
        if (capture) begin
            match_value_d = {base_q - LAT_CW, hit_idx};
            hit_count_d   = (hit_count_q == 8'hFF) ? hit_count_q : hit_count_q + 8'd1;
            multi_hit_d   = multi_hit_q | hit_multi;
        end
    end

    // Outputs: combinational pipe_en so a pause stalls the lanes in the same cycle
    always_comb begin
        pipe_en = enable && (state_q inside {ST_WARM, ST_RUN, ST_DRAIN});
        status  = STAT_V_IDLE;
        unique case (state_q)
            ST_IDLE: begin
                status = STAT_V_IDLE;
            end
            ST_WARM: begin
                status              = STAT_V_WARM;
                status[STAT_PAUSED] = !enable;
            end
            ST_RUN, ST_DRAIN: begin
                status              = STAT_V_RUN;
                status[STAT_PAUSED] = !enable;
            end
            ST_FOUND: begin
                status = STAT_V_FOUND;
            end
            ST_DONE: begin
                status             = STAT_V_DONE;
                status[STAT_FOUND] = (hit_count_q != 8'd0);
            end
            default: begin
                status = STAT_V_IDLE;
            end
        endcase
    end

    assign lanes.pipe_en  = pipe_en;
    assign lanes.base_out = base_q;

    assign status_paused  = status[STAT_PAUSED];
    assign status_running = status[STAT_RUNNING];
    assign status_warming = status[STAT_WARMING];
    assign status_found   = status[STAT_FOUND];
    assign status_done    = status[STAT_DONE];

    assign match_value = match_value_q;
    assign hit_count   = hit_count_q;
    assign multi_hit   = multi_hit_q;

endmodule
